// File: rtl/irq_event_queue.sv
// rtl/irq_event_queue.sv - tagged keyboard/Ethernet interrupt event FIFO with registered presentation FSM
module irq_event_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [7:0]    key_data,
    input  logic          eth_valid,
    input  logic [23:0]   eth_data,
    input  logic          irq_ack,
    input  logic          overflow_clr,
    output logic          interrupt_key,
    output logic          interrupt_eth,
    output logic [31:0]   interrupt_source_data,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd2;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;

    logic          pop;
    logic [CW:0]   free;
    logic          key_acc;
    logic          eth_acc;
    logic          drop;
    logic [31:0]   key_entry;
    logic [31:0]   eth_entry;
    logic [CW-1:0] count_next;
    logic [CW-1:0] remaining;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] eth_wr_ptr;
    logic [31:0]   head_next;

    always_comb begin
        key_entry   = {8'h01, 16'h0000, key_data};
        eth_entry   = {8'h02, eth_data};
        pop         = (state == S_PRESENT) && irq_ack;
        free        = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
        key_acc     = key_valid && (free != '0);
        eth_acc     = eth_valid && (key_acc ? (free >= (CW+1)'(2)) : (free >= (CW+1)'(1)));
        drop        = (key_valid && !key_acc) || (eth_valid && !eth_acc);
        count_next  = count - CW'(pop) + CW'(key_acc) + CW'(eth_acc);
        remaining   = count - CW'(pop);
        rd_ptr_next = rd_ptr + PW'(pop);
        eth_wr_ptr  = wr_ptr + PW'(key_acc);
        // When the queue drains to empty this cycle, the new head is the entry being written now.
        if (remaining != '0)
            head_next = mem[rd_ptr_next];
        else if (key_acc)
            head_next = key_entry;
        else
            head_next = eth_entry;
    end

    always_ff @(posedge clk) begin
        if (key_acc)
            mem[wr_ptr] <= key_entry;
        if (eth_acc)
            mem[eth_wr_ptr] <= eth_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            count                 <= '0;
            overflow              <= 1'b0;
            state                 <= S_IDLE;
            interrupt_key         <= 1'b0;
            interrupt_eth         <= 1'b0;
            interrupt_source_data <= 32'h0;
        end else begin
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr + PW'(key_acc) + PW'(eth_acc);
            count  <= count_next;
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;

            case (state)
                S_IDLE, S_HOLDOFF: begin
                    if (count_next != '0) begin
                        state                 <= S_PRESENT;
                        interrupt_key         <= (head_next[31:24] == 8'h01);
                        interrupt_eth         <= (head_next[31:24] == 8'h02);
                        interrupt_source_data <= head_next;
                    end else begin
                        state                 <= S_IDLE;
                        interrupt_key         <= 1'b0;
                        interrupt_eth         <= 1'b0;
                        interrupt_source_data <= 32'h0;
                    end
                end
                S_PRESENT: begin
                    if (pop) begin
                        state                 <= S_HOLDOFF;
                        interrupt_key         <= 1'b0;
                        interrupt_eth         <= 1'b0;
                        interrupt_source_data <= 32'h0;
                    end
                end
                default: begin
                    state                 <= S_IDLE;
                    interrupt_key         <= 1'b0;
                    interrupt_eth         <= 1'b0;
                    interrupt_source_data <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_event_queue.sv
// tb/tb_irq_event_queue.sv - directed self-checking bench for irq_event_queue
module tb_irq_event_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        eth_valid;
    logic [23:0] eth_data;
    logic        irq_ack;
    logic        overflow_clr;
    logic        interrupt_key;
    logic        interrupt_eth;
    logic [31:0] interrupt_source_data;
    logic [2:0]  count;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    irq_event_queue #(.DEPTH(4)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .key_valid             (key_valid),
        .key_data              (key_data),
        .eth_valid             (eth_valid),
        .eth_data              (eth_data),
        .irq_ack               (irq_ack),
        .overflow_clr          (overflow_clr),
        .interrupt_key         (interrupt_key),
        .interrupt_eth         (interrupt_eth),
        .interrupt_source_data (interrupt_source_data),
        .count                 (count),
        .overflow              (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic kv, input logic [7:0] kd, input logic ev,
                         input logic [23:0] ed, input logic ack, input logic clr);
        key_valid    = kv;
        key_data     = kd;
        eth_valid    = ev;
        eth_data     = ed;
        irq_ack      = ack;
        overflow_clr = clr;
        tick();
        key_valid    = 1'b0;
        eth_valid    = 1'b0;
        irq_ack      = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_key"},  {31'h0, interrupt_key}, 32'h0);
        check({tag, "_eth"},  {31'h0, interrupt_eth}, 32'h0);
        check({tag, "_data"}, interrupt_source_data,  32'h0);
    endtask

    // Presented head must match, then ack it and let the holdoff cycle pass.
    task automatic expect_and_ack(input string tag, input logic [31:0] exp);
        check({tag, "_data"}, interrupt_source_data, exp);
        check({tag, "_key"}, {31'h0, interrupt_key}, {31'h0, exp[31:24] == 8'h01});
        check({tag, "_eth"}, {31'h0, interrupt_eth}, {31'h0, exp[31:24] == 8'h02});
        drive(1'b0, 8'h0, 1'b0, 24'h0, 1'b1, 1'b0);
        check_idle_outputs({tag, "_holdoff"});
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        key_valid    = 1'b0;
        key_data     = 8'h0;
        eth_valid    = 1'b0;
        eth_data     = 24'h0;
        irq_ack      = 1'b0;
        overflow_clr = 1'b0;
        repeat (2) tick();
        check_idle_outputs("reset");
        check("reset_count", {29'h0, count}, 32'h0);
        check("reset_ovf", {31'h0, overflow}, 32'h0);
        rst_n = 1'b1;
        tick();

        // single key event
        drive(1'b1, 8'h1C, 1'b0, 24'h0, 1'b0, 1'b0);
        check("key1_count", {29'h0, count}, 32'd1);
        expect_and_ack("key1", 32'h0100_001C);
        check_idle_outputs("key1_idle");
        check("key1_count_end", {29'h0, count}, 32'd0);

        // simultaneous sources: key first
        drive(1'b1, 8'h05, 1'b1, 24'hABCDEF, 1'b0, 1'b0);
        check("both_count", {29'h0, count}, 32'd2);
        expect_and_ack("both_key", 32'h0100_0005);
        expect_and_ack("both_eth", 32'h02AB_CDEF);
        check("both_count_end", {29'h0, count}, 32'd0);

        // ack in IDLE with strobe: ack ignored, entry pushed
        drive(1'b1, 8'h33, 1'b0, 24'h0, 1'b1, 1'b0);
        check("idleack_count", {29'h0, count}, 32'd1);
        expect_and_ack("idleack", 32'h0100_0033);

        // overflow with 5 strobes
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 24'h0, 1'b0, 1'b0);
        check("ovf_count", {29'h0, count}, 32'd4);
        check("ovf_flag", {31'h0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++)
            expect_and_ack("ovf_drain", 32'h0100_0010 + 32'(i));
        check("ovf_count_end", {29'h0, count}, 32'd0);
        check("ovf_still_set", {31'h0, overflow}, 32'd1);
        drive(1'b0, 8'h0, 1'b0, 24'h0, 1'b0, 1'b1);
        check("ovf_cleared", {31'h0, overflow}, 32'd0);

        // full + ack + both strobes, clear coinciding with drop
        for (int i = 0; i < 4; i++)
            drive(1'b1, 8'h20 + 8'(i), 1'b0, 24'h0, 1'b0, 1'b0);
        check("full_count", {29'h0, count}, 32'd4);
        drive(1'b1, 8'h24, 1'b1, 24'h555555, 1'b1, 1'b1);
        check("full2_count", {29'h0, count}, 32'd4);
        check("full2_ovf_setwins", {31'h0, overflow}, 32'd1);
        drive(1'b0, 8'h0, 1'b0, 24'h0, 1'b0, 1'b1);
        check("full2_ovf_clr", {31'h0, overflow}, 32'd0);
        // full + ack + single strobe: accepted, no overflow
        drive(1'b1, 8'h25, 1'b0, 24'h0, 1'b1, 1'b0);
        check("full1_count", {29'h0, count}, 32'd4);
        check("full1_ovf", {31'h0, overflow}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++)
            expect_and_ack("full_drain", 32'h0100_0022 + 32'(i));
        check("full_count_end", {29'h0, count}, 32'd0);

        // pointer wrap: ack of one entry coincides with push of the next
        drive(1'b1, 8'h40, 1'b0, 24'h0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            check("wrap_data", interrupt_source_data, 32'h0100_0040 + 32'(i - 1));
            drive(1'b1, 8'h40 + 8'(i), 1'b0, 24'h0, 1'b1, 1'b0);
            check("wrap_count", {29'h0, count}, 32'd1);
            tick();
        end
        expect_and_ack("wrap_last", 32'h0100_0049);
        check("wrap_count_end", {29'h0, count}, 32'd0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 3; i++)
            drive(1'b1, 8'h60 + 8'(i), 1'b0, 24'h0, 1'b0, 1'b0);
        check("prerst_count", {29'h0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_count", {29'h0, count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'h77, 1'b0, 24'h0, 1'b0, 1'b0);
        check("postrst_count", {29'h0, count}, 32'd1);
        expect_and_ack("postrst", 32'h0100_0077);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/irq_event_queue.md
# irq_event_queue

Interrupt event queue upstream of the processor core. Accepts single-cycle event strobes from the keyboard and Ethernet receivers, buffers them with a source tag in a small FIFO, and presents the oldest event on the core's `interrupt_key`/`interrupt_eth` lines and `interrupt_source_data` bus. The core acknowledges each serviced event with `irq_ack`, and the block then presents the next entry. Events are not lost while the core's interrupt latch is set.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CW`, derived `$clog2(DEPTH+1)`: width of `count`.

- `clk` input 1: core clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_valid` input 1: single-cycle keyboard event strobe, synchronous to `clk`.
- `key_data` input 8: keyboard scan code, valid with `key_valid`.
- `eth_valid` input 1: single-cycle Ethernet event strobe, synchronous to `clk`.
- `eth_data` input 24: Ethernet payload, valid with `eth_valid`.
- `irq_ack` input 1: single-cycle pulse from the core when the current event is serviced (RTI retired).
- `overflow_clr` input 1: clears `overflow`.
- `interrupt_key` output 1: head entry is a keyboard event.
- `interrupt_eth` output 1: head entry is an Ethernet event.
- `interrupt_source_data` output 32: head entry `{tag[7:0], payload[23:0]}`; 0 when nothing is presented.
- `count` output CW: occupied entries.
- `overflow` output 1: sticky; at least one event dropped.

## Operation
- Entry encoding:
  - Keyboard: tag `8'h01`, payload `{16'h0, key_data}`.
  - Ethernet: tag `8'h02`, payload `eth_data`.
- Storage: circular buffer with `DEPTH` entries and read/write pointers that wrap modulo `DEPTH`. Full/empty status comes from `count`.
- Per-cycle order of evaluation:
  1. Pop, if one is permitted.
  2. Pushes, keyboard first, then Ethernet.
  3. Overflow update.
- Free slots this cycle = `DEPTH - count + pop`.
- Push acceptance:
  - Both strobes, 2 or more free slots: both accepted, key entry written ahead of eth.
  - Both strobes, exactly 1 free slot: key accepted, eth dropped.
  - Any strobe with 0 free slots: the event is dropped.
  - Any drop sets `overflow`.
- Overflow priority: `overflow_clr` coinciding with a drop leaves `overflow` = 1, because set wins.
- Presentation FSM:
  - IDLE: lines low, data 0.
    - Go to PRESENT when `count` becomes nonzero.
  - PRESENT: lines and data reflect the head entry. Exactly one of `interrupt_key`/`interrupt_eth` is high.
    - `irq_ack` pops the head and moves to HOLDOFF.
  - HOLDOFF: one cycle with lines low and data 0. This gives the core a clean deassertion.
    - Go to PRESENT if `count` > 0, else IDLE.
- Ignored acks: `irq_ack` in IDLE or HOLDOFF has no effect, with no pop and no state change.
- Outputs are registered. The lines never change identity within PRESENT.

## Timing
- Reset values: all outputs 0. Pointers 0, FIFO contents don't-care, state IDLE.
- Reset asserted mid-operation discards all queued entries immediately, since reset is asynchronous.
- Push latency: a strobe at edge N into an empty queue in IDLE gives the line high and data valid from N+1.
- Ack latency: `irq_ack` sampled at edge N gives lines low for cycle N+1 (HOLDOFF). The next head is presented from N+2.
- `count` updates at the same edge as the push or pop.
- Simultaneous full + ack + single strobe: the pop frees one slot, the strobe is accepted, `count` stays `DEPTH`, and no overflow.
- Simultaneous empty + strobe + ack in IDLE: the ack is ignored and the entry is pushed.
- Sustained strobes with no acks: exactly `DEPTH` entries retained, oldest first. Later events are dropped.

## Test plan
- **Single key event:** after reset, `key_valid` with `key_data=8'h1C` -> next cycle `interrupt_key`=1 and `interrupt_source_data=32'h0100_001C`, `count`=1. `irq_ack` -> one cycle of lines low, then IDLE with `count`=0.
- **Simultaneous sources:** same-cycle key `8'h05` and eth `24'hABCDEF` -> key `32'h0100_0005` is presented first. After ack and a one-cycle HOLDOFF, `interrupt_eth`=1 with data `32'h02AB_CDEF`.
- **Overflow:** 5 key strobes, no acks, `DEPTH`=4 -> `count`=4, `overflow`=1, and acks return the first four scan codes in order. `overflow_clr` -> `overflow`=0.
- **Full with ack plus one slot:** queue full, `irq_ack` with both strobes in the same cycle -> key accepted, eth dropped, `count`=4, `overflow`=1.
- **Pointer wrap:** 10 interleaved push/ack pairs -> data returned in order across the pointer wrap, and `count` never exceeds 2.
- **Reset mid-operation:** 3 entries queued, `rst_n` pulsed low mid-cycle -> all outputs 0 immediately. After release, a new key event is presented normally.
